// File: rtl/win_detector.sv
// Connect Four win detector: keeps a 7x6 board copy, writes one column per go request,
// then scans every (cell, direction) line for four-in-a-row. Macro WIN_DRAW_DETECT_EN adds the draw flag.
`timescale 1ns/1ps
module win_detector #(
   parameter int unsigned COLS    = 7,
   parameter int unsigned ROWS    = 6,
   parameter int unsigned WIN_LEN = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         logic_go,
   input  logic                         logic_reset,
   input  logic [$clog2(COLS+1)-1:0]    mem_address,
   input  logic [ROWS-1:0]              write_to_onoff,
   input  logic [ROWS-1:0]              write_to_player,
   output logic                         busy,
   output logic                         done,
   output logic                         logic_result,
   output logic                         winner,
   output logic                         draw
);

   localparam int unsigned AW = $clog2(COLS + 1);
   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned RW = $clog2(ROWS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(COLS - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [1:0]      dir_q, dir_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            result_q, result_d;
   logic            winner_q, winner_d;
   logic [ROWS-1:0] onoff_q  [COLS];
   logic [ROWS-1:0] player_q [COLS];
   logic            wr_en_c;
   logic            match_c;
   logic            anchor_c;
   logic            last_c;

   // Evaluate the line anchored at (col_q,row_q) in direction dir_q.
   always_comb begin
      int dx, dy, cx, cy;
      case (dir_q)
         2'd1:    begin dx = 0; dy = 1;  end
         2'd2:    begin dx = 1; dy = 1;  end
         2'd3:    begin dx = 1; dy = -1; end
         default: begin dx = 1; dy = 0;  end
      endcase
      anchor_c = player_q[col_q][row_q];
      match_c  = 1'b1;
      for (int i = 0; i < int'(WIN_LEN); i++) begin
         cx = int'(col_q) + i * dx;
         cy = int'(row_q) + i * dy;
         if (cx < 0 || cx >= int'(COLS) || cy < 0 || cy >= int'(ROWS))
            match_c = 1'b0;
         else if (!onoff_q[CW'(cx)][RW'(cy)] || (player_q[CW'(cx)][RW'(cy)] != anchor_c))
            match_c = 1'b0;
      end
   end

   assign last_c = (col_q == LAST_COL) && (row_q == LAST_ROW) && (dir_q == 2'd3);

`ifdef WIN_DRAW_DETECT_EN
   logic draw_q, draw_d;
   logic full_c;

   always_comb begin
      full_c = 1'b1;
      for (int c = 0; c < int'(COLS); c++)
         full_c = full_c & (&onoff_q[CW'(c)]);
   end

   assign draw = draw_q;
`else
   assign draw = 1'b0;
`endif

   // Next-state and output logic; board clear overrides everything.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      dir_d    = dir_q;
      result_d = result_q;
      winner_d = winner_q;
      wr_en_c  = 1'b0;
`ifdef WIN_DRAW_DETECT_EN
      draw_d   = draw_q;
`endif
      case (state_q)
         IDLE: begin
            if (logic_go) begin
               wr_en_c  = (mem_address <= LAST_ADDR);
               result_d = 1'b0;
               winner_d = 1'b0;
               col_d    = '0;
               row_d    = '0;
               dir_d    = '0;
               state_d  = SCAN;
`ifdef WIN_DRAW_DETECT_EN
               draw_d   = 1'b0;
`endif
            end
         end
         SCAN: begin
            if (match_c) begin
               result_d = 1'b1;
               winner_d = anchor_c;
               state_d  = DONE;
`ifdef WIN_DRAW_DETECT_EN
               draw_d   = 1'b0;
`endif
            end else if (last_c) begin
               result_d = 1'b0;
               winner_d = 1'b0;
               state_d  = DONE;
`ifdef WIN_DRAW_DETECT_EN
               draw_d   = full_c;
`endif
            end else begin
               dir_d = dir_q + 2'd1;
               if (dir_q == 2'd3) begin
                  if (row_q == LAST_ROW) begin
                     row_d = '0;
                     col_d = col_q + CW'(1);
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (logic_reset) begin
         state_d  = IDLE;
         col_d    = '0;
         row_d    = '0;
         dir_d    = '0;
         result_d = 1'b0;
         winner_d = 1'b0;
         wr_en_c  = 1'b0;
`ifdef WIN_DRAW_DETECT_EN
         draw_d   = 1'b0;
`endif
      end

      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         dir_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 1'b0;
         winner_q <= 1'b0;
         onoff_q  <= '{default: '0};
         player_q <= '{default: '0};
`ifdef WIN_DRAW_DETECT_EN
         draw_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         dir_q    <= dir_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         winner_q <= winner_d;
`ifdef WIN_DRAW_DETECT_EN
         draw_q   <= draw_d;
`endif
         if (logic_reset) begin
            onoff_q  <= '{default: '0};
            player_q <= '{default: '0};
         end else if (wr_en_c) begin
            onoff_q[CW'(mem_address)]  <= write_to_onoff;
            player_q[CW'(mem_address)] <= write_to_player;
         end
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign logic_result = result_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_win_detector.sv
// Self-checking bench for win_detector: directed vector table, multi-cycle corner sequences,
// and randomized column writes checked against a board model.
`timescale 1ns/1ps
module tb_win_detector;

   localparam int NC = 7;
   localparam int NR = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       logic_go;
   logic       logic_reset;
   logic [2:0] mem_address;
   logic [5:0] write_to_onoff;
   logic [5:0] write_to_player;
   logic       busy, done, logic_result, winner, draw;

   int n_checks = 0;
   int n_fail   = 0;
   int mo [NC][NR];
   int mp [NC][NR];

   win_detector dut (
      .clk             (clk),
      .reset           (reset),
      .logic_go        (logic_go),
      .logic_reset     (logic_reset),
      .mem_address     (mem_address),
      .write_to_onoff  (write_to_onoff),
      .write_to_player (write_to_player),
      .busy            (busy),
      .done            (done),
      .logic_result    (logic_result),
      .winner          (winner),
      .draw            (draw)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++) begin
            mo[c][r] = 0;
            mp[c][r] = 0;
         end
   endfunction

   function automatic void model_write(input int a, input logic [5:0] on, input logic [5:0] pl);
      if (a < NC)
         for (int r = 0; r < NR; r++) begin
            mo[a][r] = int'(on[r]);
            mp[a][r] = int'(pl[r]);
         end
   endfunction

   // First winning line in scan order, expressed as its index; -1 when none.
   function automatic int model_first_win(output int w);
      int dxs [4] = '{1, 0, 1, 1};
      int dys [4] = '{0, 1, 1, -1};
      w = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            for (int d = 0; d < 4; d++) begin
               int ok, x, y;
               ok = 1;
               for (int i = 0; i < 4; i++) begin
                  x = c + i * dxs[d];
                  y = r + i * dys[d];
                  if (x < 0 || x >= NC || y < 0 || y >= NR) ok = 0;
                  else if (mo[x][y] == 0 || mp[x][y] != mp[c][r]) ok = 0;
               end
               if (ok == 1) begin
                  w = mp[c][r];
                  return (c * NR + r) * 4 + d;
               end
            end
      return -1;
   endfunction

   function automatic int model_full();
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            if (mo[c][r] == 0) return 0;
      return 1;
   endfunction

   function automatic int exp_draw_of(input int k);
`ifdef WIN_DRAW_DETECT_EN
      return (k < 0 && model_full() == 1) ? 1 : 0;
`else
      return (k < -1000) ? 1 : 0;
`endif
   endfunction

   task automatic do_clear();
      logic_reset = 1'b1;
      @(posedge clk); #1;
      logic_reset = 1'b0;
      model_clear();
   endtask

   // Issue one go, follow the scan to its done pulse and check everything reported.
   task automatic do_go(input logic [2:0] a, input logic [5:0] on, input logic [5:0] pl,
                        input int exp_k, input int exp_w, input int exp_draw, input string tag);
      int  exp_lat, lat, busy_cnt;
      bit  seen;
      exp_lat = (exp_k < 0) ? 168 : exp_k + 1;
      mem_address = a; write_to_onoff = on; write_to_player = pl; logic_go = 1'b1;
      @(posedge clk); #1;
      logic_go = 1'b0;
      check({tag, " busy_after_go"}, int'(busy), 1);
      check({tag, " result_cleared"}, int'(logic_result), 0);
      check({tag, " draw_cleared"}, int'(draw), 0);
      lat = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && lat < 400) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: no done within %0d cycles", tag, lat);
      end else begin
         check({tag, " latency"}, lat, exp_lat);
         check({tag, " busy_cycles"}, busy_cnt, exp_lat);
         check({tag, " busy_at_done"}, int'(busy), 0);
         check({tag, " result"}, int'(logic_result), (exp_k >= 0) ? 1 : 0);
         check({tag, " winner"}, int'(winner), exp_w);
         check({tag, " draw"}, int'(draw), exp_draw);
      end
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, int'(done), 0);
      check({tag, " result_held"}, int'(logic_result), (exp_k >= 0) ? 1 : 0);
   endtask

   task automatic model_go(input logic [2:0] a, input logic [5:0] on, input logic [5:0] pl,
                           input string tag);
      int k, w;
      model_write(int'(a), on, pl);
      k = model_first_win(w);
      do_go(a, on, pl, k, w, exp_draw_of(k), tag);
   endtask

   typedef struct {
      bit         clr;
      logic [2:0] a;
      logic [5:0] on;
      logic [5:0] pl;
      int         k;
      int         w;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int dcount;
      logic [5:0] pl;

      vecs[0]  = '{1'b1, 3'd0, 6'b000001, 6'b000000, -1, 0};
      vecs[1]  = '{1'b1, 3'd3, 6'b001111, 6'b001111, 73, 1};
      vecs[2]  = '{1'b1, 3'd0, 6'b000001, 6'b000000, -1, 0};
      vecs[3]  = '{1'b0, 3'd1, 6'b000001, 6'b000000, -1, 0};
      vecs[4]  = '{1'b0, 3'd2, 6'b000001, 6'b000000, -1, 0};
      vecs[5]  = '{1'b0, 3'd3, 6'b000001, 6'b000000,  0, 0};
      vecs[6]  = '{1'b1, 3'd0, 6'b000001, 6'b000001, -1, 0};
      vecs[7]  = '{1'b0, 3'd1, 6'b000011, 6'b000010, -1, 0};
      vecs[8]  = '{1'b0, 3'd2, 6'b000111, 6'b000100, -1, 0};
      vecs[9]  = '{1'b0, 3'd3, 6'b001111, 6'b001000,  2, 1};
      vecs[10] = '{1'b0, 3'd7, 6'b111111, 6'b000000,  2, 1};
      vecs[11] = '{1'b1, 3'd6, 6'b000000, 6'b000000, -1, 0};

      reset = 1'b0; logic_go = 1'b0; logic_reset = 1'b0;
      mem_address = '0; write_to_onoff = '0; write_to_player = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset result", int'(logic_result), 0);
      check("reset winner", int'(winner), 0);
      check("reset draw", int'(draw), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].clr) do_clear();
         do_go(vecs[i].a, vecs[i].on, vecs[i].pl, vecs[i].k, vecs[i].w, 0,
               $sformatf("vec%0d", i));
      end

      // Board clear mid-scan aborts without a done pulse.
      do_clear();
      mem_address = 3'd0; write_to_onoff = 6'b000001; write_to_player = '0; logic_go = 1'b1;
      @(posedge clk); #1;
      logic_go = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      logic_reset = 1'b1;
      @(posedge clk); #1;
      logic_reset = 1'b0;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort result", int'(logic_result), 0);
      dcount = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      check("abort no_done", dcount, 0);
      do_go(3'd6, 6'b000000, 6'b000000, -1, 0, 0, "abort_rescan");

      // Go requests during SCAN and DONE are dropped and never write the board.
      do_clear();
      mem_address = 3'd3; write_to_onoff = 6'b001111; write_to_player = 6'b001111; logic_go = 1'b1;
      @(posedge clk); #1;
      mem_address = 3'd0; write_to_onoff = 6'b111111; write_to_player = 6'b000000;
      dcount = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         logic_go = (cyc == 10) || (done === 1'b1);
         if (done) dcount++;
         @(posedge clk); #1;
      end
      logic_go = 1'b0;
      check("ignored_go done_count", dcount, 1);
      check("ignored_go result", int'(logic_result), 1);
      check("ignored_go winner", int'(winner), 1);
      do_go(3'd7, 6'b111111, 6'b000000, 73, 1, 0, "ignored_go_rescan");

      // Board clear wins over a simultaneous go.
      do_clear();
      mem_address = 3'd0; write_to_onoff = 6'b111111; write_to_player = '0;
      logic_go = 1'b1; logic_reset = 1'b1;
      @(posedge clk); #1;
      logic_go = 1'b0; logic_reset = 1'b0;
      check("prio busy", int'(busy), 0);
      do_go(3'd7, 6'b000000, 6'b000000, -1, 0, 0, "prio_rescan");

      // Main reset mid-scan clears outputs and board.
      do_clear();
      do_go(3'd3, 6'b001111, 6'b001111, 73, 1, 0, "pre_reset");
      mem_address = 3'd7; logic_go = 1'b1;
      @(posedge clk); #1;
      logic_go = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("midreset busy", int'(busy), 0);
      check("midreset done", int'(done), 0);
      check("midreset result", int'(logic_result), 0);
      check("midreset winner", int'(winner), 0);
      do_go(3'd7, 6'b000000, 6'b000000, -1, 0, 0, "post_reset");

      // Full board with no four-in-a-row: two-row bands alternating by column.
      do_clear();
      for (int c = 0; c < NC; c++) begin
         for (int r = 0; r < NR; r++) pl[r] = 1'((r >> 1) & 1) ^ 1'(c & 1);
         model_go(3'(c), 6'b111111, pl, $sformatf("fill%0d", c));
      end
      model_go(3'd7, 6'b000000, 6'b000000, "fill_rescan");

      do_clear();
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 7) == 0) do_clear();
         model_go(3'($urandom_range(0, 7)), 6'($urandom) & 6'($urandom), 6'($urandom),
                  $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
